// File: rtl/irq_controller_pkg.sv
// Shared constants and bus request type for the platform interrupt controller.
package irq_controller_pkg;

  localparam int IRQ_ID_W = 5;

  // Word index (addr[4:2]) of each MMIO register
  localparam logic [2:0] REG_PENDING   = 3'd0;
  localparam logic [2:0] REG_ENABLE    = 3'd1;
  localparam logic [2:0] REG_EDGE_MODE = 3'd2;
  localparam logic [2:0] REG_CLAIM     = 3'd3;
  localparam logic [2:0] REG_STATUS    = 3'd4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_CLAIMED = 2'd2;

  typedef struct packed {
    logic [2:0]  idx;
    logic        wen;
    logic        ren;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser: SYNC_STAGES flops plus one delay flop for rise detection.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic sync_level,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_level = sync_q[SYNC_STAGES-1];
  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/irq_controller.sv
// Pending/enable/edge-mode register file, fixed-priority encoder and claim/complete FSM
// driving the core's level interrupt input.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [4:0]         bus_addr,
  input  logic               bus_wen,
  input  logic               bus_ren,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               interrupt
);

  logic [NUM_SRC-1:0]  sync_level, rise_pulse;
  logic [NUM_SRC-1:0]  pending, enable, edge_mode;
  logic [NUM_SRC-1:0]  pending_nxt, active, best_oh, claim_clr, w1c;
  logic [IRQ_ID_W-1:0] svc_id, best_id;
  logic [1:0]          state, state_nxt;
  logic [31:0]         rdata_nxt;
  logic                req, claim_rd, claim_wr, claim_take;
  bus_req_t            breq;

  irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_SRC-1:0] (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq_in),
    .sync_level (sync_level),
    .rise_pulse (rise_pulse)
  );

  assign breq = '{idx: bus_addr[4:2], wen: bus_wen, ren: bus_ren, wdata: bus_wdata};

  logic unused_bits;
  assign unused_bits = &{1'b0, bus_addr[1:0], bus_wdata};

  assign active = pending & enable;
  assign req    = |active;

  // Scan high to low so the lowest set index is the one left standing
  always_comb begin
    best_id = '0;
    best_oh = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        best_id = IRQ_ID_W'(i + 1);
        best_oh = '0;
        best_oh[i] = 1'b1;
      end
    end
  end

  assign claim_rd   = breq.ren && (breq.idx == REG_CLAIM);
  assign claim_wr   = breq.wen && (breq.idx == REG_CLAIM);
  assign claim_take = claim_rd && (state != ST_CLAIMED) && req;
  assign claim_clr  = claim_take ? best_oh : '0;
  assign w1c        = (breq.wen && (breq.idx == REG_PENDING)) ? breq.wdata[NUM_SRC-1:0] : '0;

  // Edge sources: a rise in the same cycle as a clear keeps the bit set
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (edge_mode[i])
        pending_nxt[i] = (pending[i] & ~(w1c[i] | claim_clr[i])) | rise_pulse[i];
      else
        pending_nxt[i] = sync_level[i];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (claim_take) state_nxt = ST_CLAIMED;
                  else if (req)   state_nxt = ST_ASSERT;
      ST_ASSERT:  if (claim_take) state_nxt = ST_CLAIMED;
                  else if (!req)  state_nxt = ST_IDLE;
      ST_CLAIMED: if (claim_wr && (breq.wdata[IRQ_ID_W-1:0] == svc_id)) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Reads see pre-write register values
  always_comb begin
    rdata_nxt = '0;
    case (breq.idx)
      REG_PENDING:   rdata_nxt = 32'(pending);
      REG_ENABLE:    rdata_nxt = 32'(enable);
      REG_EDGE_MODE: rdata_nxt = 32'(edge_mode);
      REG_CLAIM:     rdata_nxt = claim_take ? 32'(best_id) : 32'd0;
      REG_STATUS:    rdata_nxt = {22'd0, state, 3'd0, svc_id};
      default:       rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending   <= '0;
      enable    <= '0;
      edge_mode <= '0;
      svc_id    <= '0;
      state     <= ST_IDLE;
      interrupt <= 1'b0;
      bus_rdata <= '0;
    end else begin
      pending   <= pending_nxt;
      state     <= state_nxt;
      interrupt <= (state_nxt == ST_ASSERT);
      if (claim_take) svc_id <= best_id;
      if (breq.wen && (breq.idx == REG_ENABLE))    enable    <= breq.wdata[NUM_SRC-1:0];
      if (breq.wen && (breq.idx == REG_EDGE_MODE)) edge_mode <= breq.wdata[NUM_SRC-1:0];
      if (breq.ren) bus_rdata <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: latency, priority, claim/complete, W1C race, async reset.
module tb_irq_controller;

  localparam logic [4:0] A_PEND   = 5'h00;
  localparam logic [4:0] A_ENABLE = 5'h04;
  localparam logic [4:0] A_EDGE   = 5'h08;
  localparam logic [4:0] A_CLAIM  = 5'h0C;
  localparam logic [4:0] A_STATUS = 5'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  irq_in = '0;
  logic [4:0]  bus_addr = '0;
  logic        bus_wen = 1'b0;
  logic        bus_ren = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        interrupt;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;

  irq_controller #(.NUM_SRC(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .bus_addr  (bus_addr),
    .bus_wen   (bus_wen),
    .bus_ren   (bus_ren),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  // Bus tasks are entered at a negedge and return at the following negedge
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_wen = 1'b1;
    @(negedge clk);
    bus_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    bus_addr = a; bus_ren = 1'b1;
    @(negedge clk);
    bus_ren = 1'b0;
    d = bus_rdata;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL reset_int got=%b exp=0", interrupt); end
    n_cmp++; if (bus_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", bus_rdata); end
    @(negedge clk); rst = 1'b1; @(negedge clk);
    bus_read(A_STATUS, rd);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL reset_status got=%h exp=0", rd); end
  endtask

  task automatic test_regs();
    bus_write(A_ENABLE, 32'hFFFF_FFFF);
    bus_read(A_ENABLE, rd);
    n_cmp++; if (rd !== 32'hFF) begin n_err++; $display("FAIL enable_width got=%h exp=ff", rd); end
    bus_write(5'h14, 32'hFFFF);
    bus_read(5'h14, rd);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL unmapped_rd got=%h exp=0", rd); end
    // Simultaneous write and read returns the old value
    bus_addr = A_ENABLE; bus_wdata = 32'h0F; bus_wen = 1'b1; bus_ren = 1'b1;
    @(negedge clk);
    bus_wen = 1'b0; bus_ren = 1'b0;
    n_cmp++; if (bus_rdata !== 32'hFF) begin n_err++; $display("FAIL wr_rd_same got=%h exp=ff", bus_rdata); end
    bus_read(5'h07, rd);
    n_cmp++; if (rd !== 32'h0F) begin n_err++; $display("FAIL addr_lsb_ignored got=%h exp=0f", rd); end
    bus_write(A_ENABLE, 32'h0);
  endtask

  task automatic test_single_edge();
    bus_write(A_ENABLE, 32'h01);
    bus_write(A_EDGE, 32'h01);
    irq_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL t1_int_early got=%b exp=0", interrupt); end
    irq_in[0] = 1'b0;
    @(negedge clk);
    n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL t1_int_rise got=%b exp=1", interrupt); end
    bus_read(A_CLAIM, rd);
    n_cmp++; if (rd !== 32'd1) begin n_err++; $display("FAIL t1_claim got=%0d exp=1", rd); end
    n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL t1_int_fall got=%b exp=0", interrupt); end
    bus_read(A_PEND, rd);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL t1_pending got=%h exp=0", rd); end
    bus_read(A_STATUS, rd);
    n_cmp++; if (rd !== 32'h201) begin n_err++; $display("FAIL t1_status got=%h exp=201", rd); end
    bus_write(A_CLAIM, 32'd1);
    bus_read(A_STATUS, rd);
    n_cmp++; if (rd !== 32'h001) begin n_err++; $display("FAIL t1_status_done got=%h exp=001", rd); end
  endtask

  task automatic test_priority();
    bus_write(A_ENABLE, 32'hFF);
    bus_write(A_EDGE, 32'hFF);
    irq_in = 8'h24;
    repeat (4) @(negedge clk);
    n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL t2_int got=%b exp=1", interrupt); end
    bus_read(A_CLAIM, rd);
    n_cmp++; if (rd !== 32'd3) begin n_err++; $display("FAIL t2_claim3 got=%0d exp=3", rd); end
    bus_read(A_CLAIM, rd);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL t2_claim_busy got=%0d exp=0", rd); end
    bus_read(A_PEND, rd);
    n_cmp++; if (rd !== 32'h20) begin n_err++; $display("FAIL t2_pending got=%h exp=20", rd); end
    bus_write(A_CLAIM, 32'd3);
    n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL t2_int_idle got=%b exp=0", interrupt); end
    @(negedge clk);
    n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL t2_int_reraise got=%b exp=1", interrupt); end
    bus_read(A_CLAIM, rd);
    n_cmp++; if (rd !== 32'd6) begin n_err++; $display("FAIL t2_claim6 got=%0d exp=6", rd); end
    bus_write(A_CLAIM, 32'd6);
    irq_in = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_level_claim();
    bus_write(A_EDGE, 32'h00);
    irq_in[4] = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL t3_int got=%b exp=1", interrupt); end
    bus_read(A_CLAIM, rd);
    n_cmp++; if (rd !== 32'd5) begin n_err++; $display("FAIL t3_claim got=%0d exp=5", rd); end
    bus_write(A_CLAIM, 32'd2);
    bus_read(A_STATUS, rd);
    n_cmp++; if (rd !== 32'h205) begin n_err++; $display("FAIL t3_bad_complete got=%h exp=205", rd); end
    bus_write(A_CLAIM, 32'd5);
    n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL t3_int_idle got=%b exp=0", interrupt); end
    @(negedge clk);
    n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL t3_int_reraise got=%b exp=1", interrupt); end
  endtask

  task automatic test_level_release();
    irq_in[4] = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL t4_int got=%b exp=0", interrupt); end
    bus_read(A_STATUS, rd);
    n_cmp++; if (rd !== 32'h005) begin n_err++; $display("FAIL t4_status got=%h exp=005", rd); end
    bus_read(A_CLAIM, rd);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL t4_claim got=%0d exp=0", rd); end
    bus_read(A_STATUS, rd);
    n_cmp++; if (rd !== 32'h005) begin n_err++; $display("FAIL t4_status2 got=%h exp=005", rd); end
  endtask

  task automatic test_w1c_race();
    bus_write(A_ENABLE, 32'h00);
    bus_write(A_EDGE, 32'h01);
    irq_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    irq_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    bus_read(A_PEND, rd);
    n_cmp++; if (rd !== 32'h01) begin n_err++; $display("FAIL t5_pend_pre got=%h exp=01", rd); end
    // Rise pulse lands on the third posedge after the raise; the W1C is timed onto it
    irq_in[0] = 1'b1;
    @(negedge clk); @(negedge clk);
    bus_write(A_PEND, 32'h01);
    bus_read(A_PEND, rd);
    n_cmp++; if (rd !== 32'h01) begin n_err++; $display("FAIL t5_set_wins got=%h exp=01", rd); end
    bus_write(A_PEND, 32'h01);
    bus_read(A_PEND, rd);
    n_cmp++; if (rd !== 32'h00) begin n_err++; $display("FAIL t5_w1c got=%h exp=00", rd); end
    irq_in[0] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_async_reset();
    bus_write(A_EDGE, 32'hFF);
    bus_write(A_ENABLE, 32'hFF);
    irq_in = 8'h0A;
    repeat (3) @(negedge clk);
    irq_in = 8'h00;
    repeat (3) @(negedge clk);
    bus_read(A_CLAIM, rd);
    n_cmp++; if (rd !== 32'd2) begin n_err++; $display("FAIL t6_claim got=%0d exp=2", rd); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus_rdata !== 32'd0) begin n_err++; $display("FAIL t6_rdata got=%h exp=0", bus_rdata); end
    n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL t6_int got=%b exp=0", interrupt); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_read(A_PEND, rd);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL t6_pending got=%h exp=0", rd); end
    bus_read(A_ENABLE, rd);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL t6_enable got=%h exp=0", rd); end
    bus_read(A_EDGE, rd);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL t6_edge got=%h exp=0", rd); end
    bus_read(A_STATUS, rd);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL t6_status got=%h exp=0", rd); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_single_edge();
    test_priority();
    test_level_claim();
    test_level_release();
    test_w1c_race();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
